// File: rtl/zero_ones_run_monitor.sv
// Streaming all-zeros / all-ones word monitor with run-length tracking,
// one-cycle run_hit pulse and sticky flag. All outputs registered.
module zero_ones_run_monitor #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  output logic             is_zero,
  output logic             is_ones,
  output logic             match,
  output logic [CNT_W-1:0] run_cnt,
  output logic             run_hit,
  output logic             sticky_hit,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {IDLE, COUNT, HIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

  state_t           state, state_n;
  logic             zero_w, ones_w, match_w;
  logic [CNT_W-1:0] run_inc, run_cnt_n, match_cnt_n;
  logic             sticky_n, hit_n;

  always_comb begin
    state_n     = state;
    run_cnt_n   = run_cnt;
    match_cnt_n = match_cnt;
    sticky_n    = sticky_hit;
    hit_n       = 1'b0;
    zero_w      = (data == '0);
    ones_w      = (data == '1);
    case (mode)
      2'b00:   match_w = zero_w;
      2'b01:   match_w = ones_w;
      2'b10:   match_w = zero_w | ones_w;
      default: match_w = 1'b0;
    endcase
    run_inc = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;

    // clear wins over a same-cycle word: nothing is counted, no hit fires
    if (clear) begin
      state_n     = IDLE;
      run_cnt_n   = '0;
      match_cnt_n = '0;
      sticky_n    = 1'b0;
    end else if (in_valid) begin
      if (match_w) begin
        run_cnt_n   = run_inc;
        match_cnt_n = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + 1'b1;
        case (state)
          IDLE, COUNT: begin
            if (run_inc == RUN_LEN_C) begin
              state_n  = HIT;
              hit_n    = 1'b1;
              sticky_n = 1'b1;
            end else begin
              state_n = COUNT;
            end
          end
          default: state_n = HIT;
        endcase
      end else begin
        state_n   = IDLE;
        run_cnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      is_zero    <= 1'b0;
      is_ones    <= 1'b0;
      match      <= 1'b0;
      run_cnt    <= '0;
      run_hit    <= 1'b0;
      sticky_hit <= 1'b0;
      match_cnt  <= '0;
    end else begin
      out_valid  <= in_valid;
      is_zero    <= in_valid & zero_w;
      is_ones    <= in_valid & ones_w;
      match      <= in_valid & match_w;
      run_cnt    <= run_cnt_n;
      run_hit    <= hit_n;
      sticky_hit <= sticky_n;
      match_cnt  <= match_cnt_n;
    end
  end

endmodule

// File: tb/tb_zero_ones_run_monitor.sv
// Directed bench for zero_ones_run_monitor (WIDTH=8, RUN_LEN=3, CNT_W=8).
module tb_zero_ones_run_monitor;

  logic       clk = 1'b0;
  logic       rst, in_valid, clear;
  logic [7:0] data;
  logic [1:0] mode;
  logic       out_valid, is_zero, is_ones, match, run_hit, sticky_hit;
  logic [7:0] run_cnt, match_cnt;

  int total = 0;
  int bad   = 0;
  int hits;

  zero_ones_run_monitor #(.WIDTH(8), .RUN_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .mode(mode),
    .clear(clear), .out_valid(out_valid), .is_zero(is_zero), .is_ones(is_ones),
    .match(match), .run_cnt(run_cnt), .run_hit(run_hit),
    .sticky_hit(sticky_hit), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one cycle on the falling edge, sample 1ns after the rising edge
  task automatic beat(input logic r, input logic v, input logic c,
                      input logic [1:0] md, input logic [7:0] d);
    @(negedge clk);
    rst = r; in_valid = v; clear = c; mode = md; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ov"},  out_valid,  0);
    chk({tag, "_iz"},  is_zero,    0);
    chk({tag, "_io"},  is_ones,    0);
    chk({tag, "_m"},   match,      0);
    chk({tag, "_rc"},  run_cnt,    0);
    chk({tag, "_rh"},  run_hit,    0);
    chk({tag, "_sh"},  sticky_hit, 0);
    chk({tag, "_mc"},  match_cnt,  0);
  endtask

  initial begin
    logic [7:0] rc_e [4];
    logic       rh_e [4];
    logic       iz_e [4];
    logic [7:0] w    [4];

    rst = 1; in_valid = 0; clear = 0; mode = 0; data = 0;
    beat(1, 0, 0, 2'b00, 8'h00);
    beat(1, 1, 0, 2'b00, 8'h00);
    all_zero("reset");

    // four zeros back-to-back
    rc_e = '{1, 2, 3, 4};
    rh_e = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      beat(0, 1, 0, 2'b00, 8'h00);
      chk("t1_ov", out_valid, 1);
      chk("t1_rc", run_cnt, rc_e[i]);
      chk("t1_rh", run_hit, rh_e[i]);
      chk("t1_sh", sticky_hit, (i >= 2));
    end
    chk("t1_mc", match_cnt, 4);

    // idle clear
    beat(0, 0, 1, 2'b00, 8'h00);
    chk("clr_ov", out_valid, 0);
    chk("clr_rc", run_cnt, 0);
    chk("clr_mc", match_cnt, 0);
    chk("clr_sh", sticky_hit, 0);

    // broken run
    w    = '{8'h00, 8'h00, 8'h01, 8'h00};
    rc_e = '{1, 2, 0, 1};
    iz_e = '{1, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      beat(0, 1, 0, 2'b00, w[i]);
      chk("t2_rc", run_cnt, rc_e[i]);
      chk("t2_iz", is_zero, iz_e[i]);
      chk("t2_rh", run_hit, 0);
    end
    chk("t2_mc", match_cnt, 3);
    chk("t2_sh", sticky_hit, 0);

    // either mode with idle gap
    beat(0, 0, 1, 2'b00, 8'h00);
    beat(0, 1, 0, 2'b10, 8'hFF);
    chk("t3a_rc", run_cnt, 1); chk("t3a_io", is_ones, 1); chk("t3a_rh", run_hit, 0);
    beat(0, 1, 0, 2'b10, 8'h00);
    chk("t3b_rc", run_cnt, 2); chk("t3b_io", is_ones, 0); chk("t3b_iz", is_zero, 1);
    beat(0, 0, 0, 2'b10, 8'hFF);
    chk("t3g_ov", out_valid, 0); chk("t3g_rc", run_cnt, 2);
    chk("t3g_io", is_ones, 0); chk("t3g_m", match, 0); chk("t3g_rh", run_hit, 0);
    beat(0, 1, 0, 2'b10, 8'hFF);
    chk("t3c_rc", run_cnt, 3); chk("t3c_io", is_ones, 1); chk("t3c_rh", run_hit, 1);
    chk("t3c_sh", sticky_hit, 1);

    // saturation
    beat(0, 0, 1, 2'b00, 8'h00);
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      beat(0, 1, 0, 2'b01, 8'hFF);
      if (run_hit) hits++;
      if (i == 254) chk("t4_rc255", run_cnt, 255);
    end
    chk("t4_rc", run_cnt, 255);
    chk("t4_mc", match_cnt, 255);
    chk("t4_hits", hits, 1);
    chk("t4_sh", sticky_hit, 1);
    beat(0, 0, 1, 2'b01, 8'hFF);
    chk("t4c_rc", run_cnt, 0); chk("t4c_mc", match_cnt, 0); chk("t4c_sh", sticky_hit, 0);

    // clear with hit-producing word
    beat(0, 1, 0, 2'b00, 8'h00);
    beat(0, 1, 0, 2'b00, 8'h00);
    beat(0, 1, 1, 2'b00, 8'h00);
    chk("t5_rh", run_hit, 0); chk("t5_sh", sticky_hit, 0); chk("t5_rc", run_cnt, 0);
    chk("t5_iz", is_zero, 1); chk("t5_ov", out_valid, 1); chk("t5_mc", match_cnt, 0);
    beat(0, 1, 0, 2'b00, 8'h00);
    chk("t5n_rc", run_cnt, 1); chk("t5n_rh", run_hit, 0);

    // reset mid-run
    beat(0, 0, 1, 2'b00, 8'h00);
    beat(0, 1, 0, 2'b00, 8'h00);
    beat(0, 1, 0, 2'b00, 8'h00);
    chk("t6_pre", run_cnt, 2);
    beat(1, 1, 0, 2'b00, 8'h00);
    all_zero("t6rst");
    beat(0, 1, 0, 2'b00, 8'h00);
    chk("t6_rc", run_cnt, 1); chk("t6_mc", match_cnt, 1);
    beat(0, 1, 0, 2'b11, 8'h00);
    chk("t6_m11", match, 0); chk("t6_iz11", is_zero, 1); chk("t6_rc11", run_cnt, 0);
    chk("t6_mc11", match_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zero_ones_run_monitor.md
Name: zero_ones_run_monitor

Overview:
- Parametrised streaming successor to the 8-bit zero/ones detectors.
- Examines each valid WIDTH-bit word for all-zeros and/or all-ones, selected by mode.
- Tracks consecutive matching words (run length) and raises a one-cycle hit pulse plus a sticky flag when a run reaches RUN_LEN.
- Sits on a data bus as a stuck-bus / idle-pattern monitor; all outputs are registered.

Parameters:
- WIDTH, 8, data word width; legal range 1..64.
- RUN_LEN, 4, consecutive matches needed to declare a hit; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of run_cnt and match_cnt.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data is a valid word this cycle.
- data  input  WIDTH  word under test.
- mode  input  2  00 = zero detect, 01 = ones detect, 10 = either, 11 = disabled.
- clear  input  1  synchronous clear of counters and sticky flag.
- out_valid  output  1  registered copy of in_valid.
- is_zero  output  1  last valid word was all-zeros.
- is_ones  output  1  last valid word was all-ones.
- match  output  1  last valid word matched under its mode.
- run_cnt  output  CNT_W  current consecutive-match count, saturating.
- run_hit  output  1  one-cycle pulse when the run reaches RUN_LEN.
- sticky_hit  output  1  set by run_hit; held until clear or rst.
- match_cnt  output  CNT_W  total matching words since clear, saturating.

Behaviour:

Clock and reset:
- Single clock domain.
- rst is synchronous and active-high and has top priority. It forces state IDLE and drives every output to 0.

Latency:
- A word presented with in_valid in cycle N is reflected on all outputs in cycle N+1. out_valid = 1 in that cycle.

Per-word flags:
- is_zero = (data == 0).
- is_ones = (data == all ones).
- When WIDTH = 1, exactly one of is_zero and is_ones is set.
- mode is sampled together with data on each valid beat.
- match per mode:
  - 00: match = is_zero.
  - 01: match = is_ones.
  - 10: match = is_zero OR is_ones.
  - 11: match = 0. The run is broken; counters are not incremented.

Idle cycles:
- When in_valid = 0: out_valid = 0, and is_zero, is_ones and match are 0.
- run_cnt, match_cnt, sticky_hit and state hold. Idle cycles do not break a run.
- run_hit is 0.

State machine (advances only on valid beats):
- IDLE, where run_cnt = 0:
  - match and RUN_LEN = 1 -> HIT, run_cnt = 1, run_hit pulse.
  - match otherwise -> COUNT, run_cnt = 1.
  - no match -> stays IDLE.
- COUNT:
  - match -> run_cnt + 1. If the new value equals RUN_LEN -> HIT with run_hit pulse; otherwise stay in COUNT.
  - no match -> IDLE, run_cnt = 0.
- HIT:
  - match -> run_cnt increments and saturates at 2^CNT_W-1. No further run_hit pulse.
  - no match -> IDLE, run_cnt = 0.

Hit signalling:
- run_hit is asserted for exactly one cycle per run, coincident with the out_valid of the word that completes the run.
- sticky_hit is set in the same cycle as run_hit.

match_cnt:
- Increments on every matching valid word.
- Saturates at 2^CNT_W-1; no wrap.

clear:
- Zeroes run_cnt, match_cnt and sticky_hit, and sets state to IDLE.
- Takes priority over a simultaneous valid word: that word's flags and out_valid are still reported, but it is not counted, and run_hit is suppressed.
- A clear in the same cycle as a hit-producing word suppresses both run_hit and the sticky set.

Mode changes:
- Take effect on the next valid beat.
- The run continues if that word matches under the new mode; otherwise the run breaks.

Reset mid-run:
- Aborts the run immediately. The first valid word after rst deasserts starts from IDLE.

Test Plan:
- WIDTH = 8, RUN_LEN = 3, CNT_W = 8, mode = 00; reset, then words 0x00, 0x00, 0x00, 0x00 back-to-back:
  - run_cnt = 1, 2, 3, 4.
  - run_hit high only on the 3rd output cycle.
  - sticky_hit = 1 from then on; match_cnt = 4.
- mode = 00; words 0x00, 0x00, 0x01, 0x00:
  - run_cnt = 1, 2, 0, 1.
  - run_hit never asserted; match_cnt = 3; is_zero = 1, 1, 0, 1.
- mode = 10; words 0xFF, 0x00, 0xFF with an in_valid = 0 gap between the 2nd and 3rd:
  - run_cnt = 1, 2, hold at 2 during the gap, then 3 with run_hit.
  - is_ones = 1, 0, 1.
- mode = 01; 300 consecutive 0xFF words:
  - run_cnt and match_cnt saturate at 255.
  - exactly one run_hit pulse.
  - clear then returns both counters to 0 and sticky_hit to 0.
- clear asserted on the same cycle as the 3rd consecutive 0x00 (mode = 00):
  - run_hit = 0, sticky_hit = 0, run_cnt = 0, is_zero = 1, out_valid = 1.
- rst asserted after 2 matching words:
  - all outputs 0 the next cycle.
  - next 0x00 word gives run_cnt = 1.
  - mode = 11 with 0x00 input gives match = 0 and is_zero = 1.
